// File: rtl/register_dump_pkg.sv
// register_dump_pkg
// Shared constants for the register dump unit: FSM state encoding, the
// bytes-per-word constant for the default geometry, and the checksum init value.
// Optional feature macro used by the importing RTL: REG_DUMP_CHECKSUM_EN.
package register_dump_pkg;

  localparam int unsigned NB_STATE = 3;

  localparam logic [NB_STATE-1:0] ST_IDLE = 3'd0;
  localparam logic [NB_STATE-1:0] ST_LOAD = 3'd1;
  localparam logic [NB_STATE-1:0] ST_SEND = 3'd2;
  localparam logic [NB_STATE-1:0] ST_NEXT = 3'd3;
  localparam logic [NB_STATE-1:0] ST_CSUM = 3'd4;
  localparam logic [NB_STATE-1:0] ST_FIN  = 3'd5;

  localparam int unsigned DEFAULT_NB_DATA = 32;
  localparam int unsigned DEFAULT_NB_BYTE = 8;
  localparam int unsigned BYTES_PER_WORD  = DEFAULT_NB_DATA / DEFAULT_NB_BYTE;

  localparam int unsigned CSUM_INIT = 0;

  // Bytes per word for an arbitrary geometry (NB_DATA is a multiple of NB_BYTE).
  function automatic int unsigned bytes_per_word(input int unsigned nb_data,
                                                 input int unsigned nb_byte);
    return nb_data / nb_byte;
  endfunction

endpackage

// File: rtl/register_dump_unit_serializer.sv
// word_to_byte_serializer
// Loads one word and presents it as bytes, least-significant byte first, on a
// valid/ready interface. o_tx_valid/o_tx_data come straight from registers so
// they never depend combinationally on i_tx_ready.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_load_i             capture i_word_i and start presenting bytes
//   i_load_single_i      treat the loaded word as a single byte (low byte only)
//   i_word_i             word to serialize
//   o_tx_data_o          current byte
//   o_tx_valid_o         current byte valid
//   i_tx_ready_i         downstream accepts the byte this cycle
//   o_last_accept_o      the byte accepted this cycle is the word's last
module word_to_byte_serializer
  import register_dump_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_i,
  input  logic               i_load_single_i,
  input  logic [NB_DATA-1:0] i_word_i,
  output logic [NB_BYTE-1:0] o_tx_data_o,
  output logic               o_tx_valid_o,
  input  logic               i_tx_ready_i,
  output logic               o_last_accept_o
);

  localparam int unsigned BPW    = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int unsigned NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               accept;

  assign accept          = valid_q && i_tx_ready_i;
  assign o_last_accept_o = accept && (cnt_q == LAST_CNT);
  assign o_tx_data_o     = shift_q[NB_BYTE-1:0];
  assign o_tx_valid_o    = valid_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_load_i) begin
      shift_d = i_word_i;
      // A single-byte load starts at the last count so one accept ends it.
      cnt_d   = i_load_single_i ? LAST_CNT : '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shift_d = shift_q >> NB_BYTE;
      if (cnt_q == LAST_CNT) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/register_dump_unit.sv
// register_dump_unit
// On i_start (while idle) sweeps register addresses 0..N_REGISTERS-1, reads each
// word through the bank's combinational read port and streams it out as bytes
// (LSB first) over a valid/ready interface toward the UART transmitter.
// Optional macro REG_DUMP_CHECKSUM_EN: appends one byte holding the XOR of all
// transmitted bytes after the last register.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          one-cycle dump request, ignored unless idle
//   o_rd_addr        registered bank read address
//   i_rd_data        bank read data (combinational from o_rd_addr)
//   o_tx_data        byte to transmit
//   o_tx_valid       o_tx_data valid
//   i_tx_ready       transmitter accepts this cycle
//   o_busy           dump in progress
//   o_done           one-cycle pulse at the end of a dump
module register_dump_unit
  import register_dump_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_ADDRESS  = 5,
  parameter int unsigned N_REGISTERS = 32,
  parameter int unsigned NB_BYTE     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [NB_ADDRESS-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0]    i_rd_data,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_REGISTERS - 1);

  logic [NB_STATE-1:0]   state_q, state_d;
  logic [NB_ADDRESS-1:0] addr_q, addr_d;
  logic                  done_q, busy_q;

  logic                  ser_load;
  logic                  ser_single;
  logic [NB_DATA-1:0]    ser_word;
  logic                  ser_last_accept;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && i_start)
      csum_d = NB_BYTE'(CSUM_INIT);
    else if (state_q == ST_SEND && o_tx_valid && i_tx_ready)
      csum_d = csum_q ^ o_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) csum_q <= NB_BYTE'(CSUM_INIT);
    else         csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ser_load   = 1'b0;
    ser_single = 1'b0;
    ser_word   = i_rd_data;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The only cycle i_rd_data is captured; later bank writes cannot
        // disturb the word in flight.
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last_accept) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
          ser_load   = 1'b1;
          ser_single = 1'b1;
          ser_word   = NB_DATA'(csum_q);
          state_d    = ST_CSUM;
`else
          state_d    = ST_FIN;
`endif
        end else begin
          addr_d  = addr_q + NB_ADDRESS'(1);
          state_d = ST_LOAD;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (ser_last_accept) state_d = ST_FIN;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      // Done pulses the cycle after FIN; busy stays up through that cycle.
      done_q  <= (state_q == ST_FIN);
      busy_q  <= (state_d != ST_IDLE) || (state_q == ST_FIN);
    end
  end

  word_to_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_load_i        (ser_load),
    .i_load_single_i (ser_single),
    .i_word_i        (ser_word),
    .o_tx_data_o     (o_tx_data),
    .o_tx_valid_o    (o_tx_valid),
    .i_tx_ready_i    (i_tx_ready),
    .o_last_accept_o (ser_last_accept)
  );

  assign o_rd_addr = addr_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_register_dump_unit.sv
// Testbench for register_dump_unit: a behavioural register bank, a byte monitor
// and a reference model that lists the expected byte stream from a snapshot of
// the bank. Build with +define+REG_DUMP_CHECKSUM_EN to cover the checksum byte.
module tb_register_dump_unit;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int N_REG   = 32;
  localparam int NB_BYTE = 8;
  localparam int BPW     = NB_DATA / NB_BYTE;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif
  localparam int DUMP_CYCLES = (BPW + 2) * N_REG + 2 + CSUM_EXTRA;

  logic               clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_start = 1'b0;
  logic               i_tx_ready = 1'b1;
  logic [NB_ADDR-1:0] o_rd_addr;
  logic [NB_DATA-1:0] i_rd_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid, o_busy, o_done;

  logic [NB_DATA-1:0] bank [N_REG];
  assign i_rd_data = bank[o_rd_addr];

  register_dump_unit #(
    .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDR), .N_REGISTERS(N_REG), .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, first_vld_cyc = -1, start_cyc = 0;
  int rdy_mode = 0;  // 0: ready always high, 1: ready low ~30% of cycles
  bit stall_prev = 1'b0;
  logic [NB_BYTE-1:0] stall_data = '0;
  logic [NB_BYTE-1:0] got[$];
  logic [NB_BYTE-1:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) i_tx_ready = ($urandom_range(0, 99) >= 30);
    else               i_tx_ready = 1'b1;
  end

  // Monitor: collects accepted bytes, done pulses, and checks hold-while-stalled.
  always @(negedge clk) begin
    cyc++;
    if (stall_prev) begin
      vectors++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== stall_data) begin
        errors++;
        $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                 o_tx_valid, o_tx_data, stall_data);
      end
    end
    if (o_tx_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) got.push_back(o_tx_data);
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    stall_prev = (o_tx_valid === 1'b1) && !i_tx_ready && !i_reset;
    stall_data = o_tx_data;
  end

  // Reference model: the whole dump as a byte list from a bank snapshot.
  task automatic build_expected();
    logic [NB_BYTE-1:0] x, b;
    x = '0;
    exp_q.delete();
    for (int r = 0; r < N_REG; r++)
      for (int k = 0; k < BPW; k++) begin
        b = bank[r][k*NB_BYTE +: NB_BYTE];
        exp_q.push_back(b);
        x = x ^ b;
      end
    if (CSUM_EXTRA == 1) exp_q.push_back(x);
  endtask

  task automatic start_dump();
    build_expected();
    got.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_vld_cyc = -1;
    @(posedge clk); #1;
    i_start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: o_done not seen in %0d cycles", name, n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_bytes(input string name);
    int n;
    vectors++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte[%0d]: got %h, required %h", name, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_done_once(input string name);
    vectors++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_cnt);
    end
  endtask

  task automatic randomize_bank();
    for (int r = 0; r < N_REG; r++) bank[r] = $urandom;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    vectors += 5;
    if (o_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h, required 0", o_rd_addr); end
    if (o_tx_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", o_tx_data); end
    if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", o_tx_valid); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", o_done); end
    // Start together with reset: reset wins, nothing begins.
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 2;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL start_with_reset_busy: got %b, required 0", o_busy); end
    if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL start_with_reset_valid: got %b, required 0", o_tx_valid); end
  endtask

  task automatic test_basic_dump();
    rdy_mode = 0;
    for (int r = 0; r < N_REG; r++) bank[r] = 32'h1000_0000 + r;
    start_dump();
    vectors++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, required 1", o_busy); end
    wait_done("basic");
    check_bytes("basic");
    check_done_once("basic");
    vectors += 4;
    if (got.size() >= 4 && {got[3], got[2], got[1], got[0]} !== 32'h1000_0000) begin
      errors++;
      $display("FAIL basic_first4: got %h %h %h %h, required 00 00 00 10", got[0], got[1], got[2], got[3]);
    end
    if (got.size() >= 128 && {got[127], got[126], got[125], got[124]} !== 32'h1000_001F) begin
      errors++;
      $display("FAIL basic_last4: got %h %h %h %h, required 1f 00 00 10", got[124], got[125], got[126], got[127]);
    end
    if (first_vld_cyc !== start_cyc + 2) begin
      errors++;
      $display("FAIL basic_first_valid_cycle: got %0d, required %0d", first_vld_cyc - start_cyc, 2);
    end
    if (done_cyc !== start_cyc + DUMP_CYCLES) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d, required %0d", done_cyc - start_cyc, DUMP_CYCLES);
    end
    vectors++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b, required 0", o_busy); end
  endtask

  task automatic test_backpressure();
    randomize_bank();
    rdy_mode = 1;
    start_dump();
    wait_done("backpressure");
    check_bytes("backpressure");
    check_done_once("backpressure");
    rdy_mode = 0;
  endtask

  task automatic test_start_while_busy();
    int n = 0;
    randomize_bank();
    rdy_mode = 1;
    start_dump();
    while (got.size() < 10 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done("busy_start");
    repeat (250) @(posedge clk);
    #1;
    check_bytes("busy_start");
    check_done_once("busy_start");
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_dump();
    int n = 0;
    randomize_bank();
    rdy_mode = 0;
    start_dump();
    // Wait until reg 5 byte 2 (stream index 22) is being presented.
    while (!(got.size() == 5 * BPW + 2 && o_tx_valid === 1'b1 && o_rd_addr === 5) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 2000) begin errors++; $display("FAIL reset_mid_reach: reg5 byte2 not reached, n=%0d", n); end
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    vectors += 4;
    if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b, required 0", o_tx_valid); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, required 0", o_busy); end
    if (o_rd_addr !== '0) begin errors++; $display("FAIL reset_mid_addr: got %h, required 0", o_rd_addr); end
    if (o_tx_data !== '0) begin errors++; $display("FAIL reset_mid_data: got %h, required 0", o_tx_data); end
    repeat (250) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses, required 0", done_cnt); end
    randomize_bank();
    start_dump();
    wait_done("after_reset");
    check_bytes("after_reset");
    check_done_once("after_reset");
  endtask

  task automatic test_concurrent_write();
    int n = 0;
    randomize_bank();
    bank[3] = 32'h1122_3344;
    rdy_mode = 1;
    start_dump();
    while (!(o_rd_addr === 3 && o_tx_valid === 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    bank[3] = 32'hDEAD_BEEF;
    wait_done("conc_write");
    check_bytes("conc_write");
    check_done_once("conc_write");
    rdy_mode = 0;
  endtask

`ifdef REG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    rdy_mode = 1;
    for (int r = 0; r < N_REG; r++) bank[r] = 32'h0102_0304;
    start_dump();
    wait_done("csum_all");
    check_bytes("csum_all");
    vectors++;
    if (got.size() !== 129 || got[got.size()-1] !== 8'h00) begin
      errors++;
      $display("FAIL csum_all_final: size %0d, last byte %h, required 129 and 00",
               got.size(), (got.size() > 0) ? got[got.size()-1] : 8'hxx);
    end
    for (int r = 0; r < N_REG; r++) bank[r] = '0;
    bank[0] = 32'h0000_00FF;
    start_dump();
    wait_done("csum_ff");
    check_bytes("csum_ff");
    vectors++;
    if (got.size() !== 129 || got[got.size()-1] !== 8'hFF) begin
      errors++;
      $display("FAIL csum_ff_final: size %0d, last byte %h, required 129 and ff",
               got.size(), (got.size() > 0) ? got[got.size()-1] : 8'hxx);
    end
    rdy_mode = 0;
  endtask
`endif

  initial begin
    for (int r = 0; r < N_REG; r++) bank[r] = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic_dump();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_dump();
    test_concurrent_write();
`ifdef REG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
